spike_event_packer: RTL and testbench
=====================================

SPIKE_EVENT_PACKER -- requirements
Module: spike_event_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, event FIFO depth in entries; power of 2, range 2..64.
REQ-002 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port In  input  32  detector word: bit 31 = spike flag, bits 30:0 = running mean.
REQ-005 SHALL have port s_valid  input  1  In qualifier; no backpressure to the source.
REQ-006 SHALL have port m_axis_tdata  output  32  AXI-Stream event beat data.
REQ-007 SHALL have port m_axis_tvalid  output  1  beat valid.
REQ-008 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-009 SHALL have port m_axis_tlast  output  1  high on final beat of each event packet.
REQ-010 SHALL have port overflow  output  1  sticky flag: at least one event dropped since reset.
REQ-011 SHALL have port drop_count  output  16  number of dropped events, saturating at 16'hFFFF.

Function
REQ-012 SHALL keep a 32-bit sample index, incremented on every cycle with s_valid=1, wrapping 32'hFFFFFFFF -> 0.
REQ-013 Event time stamp SHALL be the sample index value before that cycle's increment; first sample after reset is stamped 0.
REQ-014 On s_valid=1 with In[31]=1 SHALL form an event {stamp[31:0], 1'b0, In[30:0]}; In[31]=0 or s_valid=0 creates no event.
REQ-015 Events SHALL be stored in a DEPTH-entry FIFO with an occupancy count of 0..DEPTH.
REQ-016 Push SHALL be accepted only if occupancy < DEPTH at the start of the cycle, even if a pop occurs in the same cycle.
REQ-017 A refused push SHALL set overflow and increment drop_count (saturating); the sample index still increments.
REQ-018 Simultaneous accepted push and pop SHALL leave occupancy unchanged, and read/write pointers SHALL wrap modulo DEPTH.
REQ-019 Output FSM states: IDLE, BEAT_TS, BEAT_MEAN.
REQ-020 IDLE -> BEAT_TS when FIFO is non-empty; outputs are registered, so tvalid rises one edge after the FSM observes the non-empty FIFO.
REQ-021 BEAT_TS SHALL drive tdata=stamp, tlast=0, tvalid=1, and advance to BEAT_MEAN on tvalid&tready.
REQ-022 BEAT_MEAN SHALL drive tdata={1'b0, mean[30:0]}, tlast=1, tvalid=1; on tvalid&tready it SHALL pop the FIFO.
REQ-023 From BEAT_MEAN after the pop, the FSM SHALL go to BEAT_TS if further entries remain, otherwise to IDLE, so back-to-back packets run without a bubble.
REQ-024 While tvalid=1 and tready=0, tdata, tlast and state SHALL hold stable; tvalid SHALL never drop without a handshake.
REQ-025 Minimum latency SHALL be: spike sampled at edge E -> first beat valid after edge E+1 -> tlast beat no earlier than after edge E+2.
REQ-026 Events SHALL leave in arrival order; no event SHALL be duplicated or reordered.
REQ-027 tready SHALL be ignored in IDLE, with tvalid=0 and tdata=0 there.

Reset
REQ-028 RST=1 at a clock edge SHALL clear: sample index, FIFO pointers and occupancy, FSM->IDLE, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, overflow=0, drop_count=0.
REQ-029 RST mid-packet SHALL abandon the packet and discard all queued events; no beat from a pre-reset event SHALL appear after reset.
REQ-030 A spike input present in the same cycle as RST=1 SHALL be ignored.

Verification
REQ-031 Single event: after reset, tready=1, send 3 non-spike words, then In=32'h8000_0064 -> beats 32'h0000_0003 (tlast=0), then 32'h0000_0064 (tlast=1), first beat 1 cycle after input.
REQ-032 Backpressure: hold tready=0 for 5 cycles during BEAT_TS, then 1 -> tdata/tlast stable throughout, exactly 2 beats, no loss.
REQ-033 Overflow: tready=0, feed DEPTH+3 consecutive spikes -> overflow=1, drop_count=3; release tready -> DEPTH packets with stamps 0..DEPTH-1 in order.
REQ-034 Full with simultaneous pop: FIFO full, push coincides with BEAT_MEAN handshake -> push refused, drop_count+1, occupancy DEPTH-1.
REQ-035 Wrap: force sample index to 32'hFFFF_FFFF, then 2 spikes -> stamps 32'hFFFF_FFFF then 32'h0000_0000.
REQ-036 Reset mid-packet: assert RST during BEAT_MEAN with 2 queued events -> tvalid=0 next cycle, no further beats, the next spike is stamped 0.

Source files
------------

// File: rtl/spike_event_packer_if.sv
// Detector input and AXI-Stream event output of the spike event packer.
// The slave modport is the packer's view; master is the surrounding system.
interface spike_event_packer_if;
    logic [31:0] In;
    logic        s_valid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        overflow;
    logic [15:0] drop_count;

    modport slave (
        input  In, s_valid, m_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, overflow, drop_count
    );

    modport master (
        output In, s_valid, m_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, overflow, drop_count
    );
endinterface

// File: rtl/spike_event_packer.sv
// Time-stamps detector spikes, queues them, and emits each event as a
// two-beat AXI-Stream packet: stamp, then {0, mean} with tlast.
module spike_event_packer #(
    parameter int DEPTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    spike_event_packer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];
    localparam logic [AW:0] ONE_OCC  = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] BEAT_TS   = 2'd1;
    localparam logic [1:0] BEAT_MEAN = 2'd2;

    logic [31:0]   sample_idx;
    logic [31:0]   ts_mem   [DEPTH];
    logic [30:0]   mean_mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_nxt;
    logic [AW:0]   occ;
    logic [1:0]    state;
    logic          push_req, full, push, pop;

    logic [31:0]   tdata;
    logic          tvalid, tlast, ovf;
    logic [15:0]   drops;

    assign push_req = bus.s_valid & bus.In[31];
    // Fullness is judged on start-of-cycle occupancy; a same-cycle pop does not make room.
    assign full     = (occ == FULL_OCC);
    assign push     = push_req & ~full;
    assign pop      = (state == BEAT_MEAN) & bus.m_axis_tready;
    assign rptr_nxt = rptr + 1'b1;

    always_ff @(posedge CLK) begin
        if (push) begin
            ts_mem[wptr]   <= sample_idx;
            mean_mem[wptr] <= bus.In[30:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sample_idx <= '0;
            wptr       <= '0;
            rptr       <= '0;
            occ        <= '0;
            ovf        <= 1'b0;
            drops      <= '0;
        end else begin
            if (bus.s_valid)
                sample_idx <= sample_idx + 32'd1;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr_nxt;
            occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (push_req && full) begin
                ovf <= 1'b1;
                if (drops != 16'hFFFF)
                    drops <= drops + 16'd1;
            end
        end
    end

    // Outputs are registered; in BEAT_MEAN the next head is preloaded so packets chain without a gap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (occ != '0) begin
                        state  <= BEAT_TS;
                        tvalid <= 1'b1;
                        tdata  <= ts_mem[rptr];
                        tlast  <= 1'b0;
                    end
                end
                BEAT_TS: begin
                    if (bus.m_axis_tready) begin
                        state <= BEAT_MEAN;
                        tdata <= {1'b0, mean_mem[rptr]};
                        tlast <= 1'b1;
                    end
                end
                BEAT_MEAN: begin
                    if (bus.m_axis_tready) begin
                        if (occ > ONE_OCC) begin
                            state <= BEAT_TS;
                            tdata <= ts_mem[rptr_nxt];
                            tlast <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            tvalid <= 1'b0;
                            tdata  <= '0;
                            tlast  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    tvalid <= 1'b0;
                    tdata  <= '0;
                    tlast  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m_axis_tdata  = tdata;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tlast  = tlast;
    assign bus.overflow      = ovf;
    assign bus.drop_count    = drops;
endmodule

// File: tb/tb_spike_event_packer.sv
// Directed bench for spike_event_packer: latency, backpressure, overflow,
// full-with-pop, stamp wrap and mid-packet reset.
module tb_spike_event_packer;
    localparam int DEPTH = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    spike_event_packer_if bus ();

    spike_event_packer #(.DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int nchk = 0;
    int nerr = 0;
    logic [32:0] beats [$];

    // Inputs change just after posedge, so a negedge sample sees exactly what the next edge will.
    always @(negedge CLK)
        if (!RST && bus.m_axis_tvalid && bus.m_axis_tready)
            beats.push_back({bus.m_axis_tlast, bus.m_axis_tdata});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST         = 1'b1;
        bus.s_valid = 1'b0;
        bus.In      = '0;
        tick(2);
        RST = 1'b0;
        beats.delete();
    endtask

    task automatic spike(input logic [30:0] mean);
        bus.s_valid = 1'b1;
        bus.In      = {1'b1, mean};
        tick();
        bus.s_valid = 1'b0;
        bus.In      = '0;
    endtask

    function automatic logic [32:0] beat(input int i);
        if (i < beats.size()) return beats[i];
        return 'x;
    endfunction

    task automatic chk_pkt(input string tag, input int i, input logic [31:0] ts, input logic [30:0] mean);
        chk({tag, "_ts"},   beat(i),     {1'b0, ts});
        chk({tag, "_mean"}, beat(i + 1), {2'b10, mean});
    endtask

    initial begin
        bus.m_axis_tready = 1'b1;
        bus.s_valid       = 1'b0;
        bus.In            = '0;

        // reset state
        do_reset();
        chk("rst_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_tdata",  bus.m_axis_tdata,  0);
        chk("rst_tlast",  bus.m_axis_tlast,  0);
        chk("rst_ovf",    bus.overflow,      0);
        chk("rst_drops",  bus.drop_count,    0);

        // single event after three plain samples, minimum latency
        bus.s_valid = 1'b1;
        bus.In      = 32'h0000_0001;
        tick(3);
        spike(31'h64);
        chk("lat_e0_tvalid", bus.m_axis_tvalid, 0);
        tick();
        chk("lat_e1_tvalid", bus.m_axis_tvalid, 1);
        chk("lat_e1_tdata",  bus.m_axis_tdata,  32'h0000_0003);
        chk("lat_e1_tlast",  bus.m_axis_tlast,  0);
        tick();
        chk("lat_e2_tdata",  bus.m_axis_tdata,  32'h0000_0064);
        chk("lat_e2_tlast",  bus.m_axis_tlast,  1);
        tick();
        chk("idle_tvalid",   bus.m_axis_tvalid, 0);
        chk("idle_tdata",    bus.m_axis_tdata,  0);
        chk("single_nbeats", beats.size(), 2);
        chk_pkt("single", 0, 32'h3, 31'h64);

        // backpressure in BEAT_TS for five cycles; stamp continues at 4
        beats.delete();
        bus.m_axis_tready = 1'b0;
        spike(31'hAAA);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp%0d_tvalid", k), bus.m_axis_tvalid, 1);
            chk($sformatf("bp%0d_tdata", k),  bus.m_axis_tdata,  32'h4);
            chk($sformatf("bp%0d_tlast", k),  bus.m_axis_tlast,  0);
        end
        bus.m_axis_tready = 1'b1;
        tick();
        chk("bp_mean_tdata", bus.m_axis_tdata, 32'hAAA);
        chk("bp_mean_tlast", bus.m_axis_tlast, 1);
        tick(3);
        chk("bp_nbeats", beats.size(), 2);
        chk_pkt("bp", 0, 32'h4, 31'hAAA);

        // overflow: DEPTH+3 consecutive spikes with the sink stalled
        bus.m_axis_tready = 1'b0;
        do_reset();
        for (int k = 0; k < DEPTH + 3; k++) spike(31'(100 + k));
        tick();
        chk("ovf_flag",  bus.overflow,   1);
        chk("ovf_drops", bus.drop_count, 3);
        bus.m_axis_tready = 1'b1;
        tick(2 * DEPTH + 4);
        chk("ovf_nbeats", beats.size(), 2 * DEPTH);
        for (int k = 0; k < DEPTH; k++)
            chk_pkt($sformatf("ovf_pkt%0d", k), 2 * k, 32'(k), 31'(100 + k));
        chk("ovf_sticky", bus.overflow, 1);

        // full FIFO: push coincides with the BEAT_MEAN pop and is still refused
        bus.m_axis_tready = 1'b0;
        do_reset();
        chk("rst2_ovf", bus.overflow, 0);
        for (int k = 0; k < DEPTH; k++) spike(31'(200 + k));
        tick(2);
        bus.m_axis_tready = 1'b1;
        tick();
        chk("full_in_mean", bus.m_axis_tlast, 1);
        bus.s_valid = 1'b1;
        bus.In      = {1'b1, 31'h3FF};
        tick();
        bus.s_valid = 1'b0;
        bus.In      = '0;
        chk("full_drops", bus.drop_count, 1);
        chk("full_ovf",   bus.overflow,   1);
        chk("full_occ",   dut.occ,        DEPTH - 1);
        tick(2 * DEPTH + 4);
        chk("full_nbeats", beats.size(), 2 * DEPTH);
        chk_pkt("full_last", 2 * DEPTH - 2, 32'(DEPTH - 1), 31'(200 + DEPTH - 1));

        // sample index wrap
        do_reset();
        force dut.sample_idx = 32'hFFFF_FFFF;
        tick();
        release dut.sample_idx;
        spike(31'h11);
        spike(31'h22);
        tick(8);
        chk("wrap_nbeats", beats.size(), 4);
        chk_pkt("wrap0", 0, 32'hFFFF_FFFF, 31'h11);
        chk_pkt("wrap1", 2, 32'h0000_0000, 31'h22);

        // reset during BEAT_MEAN with two queued events, spike present during reset
        bus.m_axis_tready = 1'b0;
        do_reset();
        spike(31'h31);
        spike(31'h32);
        bus.m_axis_tready = 1'b1;
        tick();
        bus.m_axis_tready = 1'b0;
        chk("mid_in_mean", bus.m_axis_tlast, 1);
        RST               = 1'b1;
        bus.m_axis_tready = 1'b1;
        bus.s_valid       = 1'b1;
        bus.In            = {1'b1, 31'h77};
        tick();
        bus.s_valid = 1'b0;
        bus.In      = '0;
        chk("mid_tvalid", bus.m_axis_tvalid, 0);
        RST = 1'b0;
        beats.delete();
        tick(4);
        chk("mid_nbeats",  beats.size(), 0);
        chk("mid_quiet",   bus.m_axis_tvalid, 0);
        spike(31'h55);
        tick(4);
        chk("mid_after_nbeats", beats.size(), 2);
        chk_pkt("mid_after", 0, 32'h0, 31'h55);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
